spi_pwm_cfg_ctrl: RTL and testbench

- SPI (mode 0) write-only configuration controller that programs the PWM output datapath of the top-level TinyTapeout user project.
- Samples the external SPI pins (sclk, copi, ncs) through synchronizers in the system clock domain.
- Decodes 16-bit write frames and updates five 8-bit configuration registers: output enables, PWM-mode enables and the PWM duty cycle.
- Sits between the ui_in pins and the PWM generator; all of its outputs drive the PWM generator directly.

---
 rtl/spi_pwm_cfg_ctrl.sv | 137 +++++++++++++
 tb/tb_spi_pwm_cfg_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_cfg_ctrl.sv
// SPI mode-0 write-only configuration controller for the PWM output datapath.
// Five 8-bit registers are loaded from 16-bit frames: {wr, addr[6:0], data[7:0]}.
module spi_pwm_cfg_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       cfg_wr_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sclk_d_q;
    logic                   ncs_d_q;

    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_fall, ncs_rise;

    logic [4:0]             bit_cnt_q;
    logic [15:0]            shift_q;
    logic                   ovf_q;
    logic                   commit_ok;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d_q;
    assign ncs_fall  = ncs_d_q & ~ncs_s;
    assign ncs_rise  = ~ncs_d_q & ncs_s;

    // Equal-depth synchronizers keep copi aligned with sclk; one extra copy for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_d_q    <= 1'b0;
            ncs_d_q     <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_d_q    <= sclk_s;
            ncs_d_q     <= ncs_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a frame spans ncs low; COMMIT lasts exactly one clk.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ncs_fall) state_d = ST_SHIFT;
            ST_SHIFT:  if (ncs_rise) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bit capture: shift MSB-first on sclk rise, saturate at 16 and flag overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ovf_q     <= 1'b0;
        end else if (state_q == ST_IDLE && ncs_fall) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ovf_q     <= 1'b0;
        end else if (state_q == ST_SHIFT && sclk_rise && !ncs_s) begin
            if (bit_cnt_q == 5'd16) begin
                ovf_q <= 1'b1;
            end else begin
                shift_q   <= {shift_q[14:0], copi_s};
                bit_cnt_q <= bit_cnt_q + 5'd1;
            end
        end
    end

    // Only an exact 16-bit write frame to a valid address is committed.
    always_comb begin
        commit_ok = (state_q == ST_COMMIT) && (bit_cnt_q == 5'd16) && !ovf_q &&
                    shift_q[15] && (shift_q[14:8] <= MAX_ADDR);
    end

    // Configuration registers and the write strobe, updated in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            cfg_wr_pulse    <= 1'b0;
        end else begin
            cfg_wr_pulse <= commit_ok;
            if (commit_ok) begin
                case (shift_q[14:8])
                    7'h00:   en_reg_out_7_0  <= shift_q[7:0];
                    7'h01:   en_reg_out_15_8 <= shift_q[7:0];
                    7'h02:   en_reg_pwm_7_0  <= shift_q[7:0];
                    7'h03:   en_reg_pwm_15_8 <= shift_q[7:0];
                    7'h04:   pwm_duty_cycle  <= shift_q[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
// Directed bench for spi_pwm_cfg_ctrl: SPI frames at sclk = clk/10.
module tb_spi_pwm_cfg_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       cfg_wr_pulse;

    int total;
    int bad;
    int pulse_cnt;
    int exp_pulses;

    spi_pwm_cfg_ctrl #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .cfg_wr_pulse    (cfg_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (cfg_wr_pulse) pulse_cnt = pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        check({tag, ".out_7_0"},  {24'h0, en_reg_out_7_0},  {24'h0, e0});
        check({tag, ".out_15_8"}, {24'h0, en_reg_out_15_8}, {24'h0, e1});
        check({tag, ".pwm_7_0"},  {24'h0, en_reg_pwm_7_0},  {24'h0, e2});
        check({tag, ".pwm_15_8"}, {24'h0, en_reg_pwm_15_8}, {24'h0, e3});
        check({tag, ".duty"},     {24'h0, pwm_duty_cycle},  {24'h0, e4});
    endtask

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic ncs_low();
        ncs = 1'b0;
        wait_clk(5);
    endtask

    // Shift n bits of v out MSB-first, mode 0 (data set while sclk low).
    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            wait_clk(5);
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
        wait_clk(5);
    endtask

    task automatic ncs_high();
        ncs = 1'b1;
        wait_clk(8);
    endtask

    task automatic send(input logic [31:0] v, input int n);
        ncs_low();
        shift_bits(v, n);
        ncs_high();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        pulse_cnt  = 0;
        exp_pulses = 0;
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;

        // Reset state.
        wait_clk(3);
        check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("reset.pulse", {31'h0, cfg_wr_pulse}, 32'h0);
        rst_n = 1'b1;
        wait_clk(3);
        check_regs("post_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // Duty write with exact latency: update lands on the 4th edge after ncs rises.
        ncs_low();
        shift_bits(32'h8480, 16);
        ncs = 1'b1;
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        check("lat.duty_before", {24'h0, pwm_duty_cycle}, 32'h00);
        check("lat.pulse_before", {31'h0, cfg_wr_pulse}, 32'h0);
        @(posedge clk);
        #1;
        check("lat.duty_at4", {24'h0, pwm_duty_cycle}, 32'h80);
        check("lat.pulse_at4", {31'h0, cfg_wr_pulse}, 32'h1);
        @(posedge clk);
        #1;
        check("lat.pulse_after", {31'h0, cfg_wr_pulse}, 32'h0);
        wait_clk(6);
        exp_pulses = exp_pulses + 1;
        check("duty.pulse_count", pulse_cnt, exp_pulses);
        check_regs("duty", 8'h00, 8'h00, 8'h00, 8'h00, 8'h80);

        // All-address sweep.
        send(32'h80F0, 16);
        send(32'h810F, 16);
        send(32'h82AA, 16);
        send(32'h8355, 16);
        send(32'h843C, 16);
        exp_pulses = exp_pulses + 5;
        check("sweep.pulse_count", pulse_cnt, exp_pulses);
        check_regs("sweep", 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h3C);
        send(32'h8201, 16);
        exp_pulses = exp_pulses + 1;
        check("rewrite.pulse_count", pulse_cnt, exp_pulses);
        check_regs("rewrite", 8'hF0, 8'h0F, 8'h01, 8'h55, 8'h3C);

        // Rejected frames: read, out-of-range, short, long.
        send(32'h04FF, 16);
        check_regs("rej_read", 8'hF0, 8'h0F, 8'h01, 8'h55, 8'h3C);
        send(32'h8512, 16);
        check_regs("rej_addr", 8'hF0, 8'h0F, 8'h01, 8'h55, 8'h3C);
        send(32'h8477 >> 1, 15);
        check_regs("rej_15bit", 8'hF0, 8'h0F, 8'h01, 8'h55, 8'h3C);
        send({15'h0, 16'h8477, 1'b1}, 17);
        check_regs("rej_17bit", 8'hF0, 8'h0F, 8'h01, 8'h55, 8'h3C);
        check("rej.pulse_count", pulse_cnt, exp_pulses);

        // ncs while idle: sclk toggling with ncs high is ignored.
        shift_bits(32'h8099, 16);
        wait_clk(8);
        check_regs("ncs_high_toggle", 8'hF0, 8'h0F, 8'h01, 8'h55, 8'h3C);
        check("ncs_high.pulse_count", pulse_cnt, exp_pulses);

        // Abort after 8 bits, then a full frame.
        send(32'h81, 8);
        check_regs("abort", 8'hF0, 8'h0F, 8'h01, 8'h55, 8'h3C);
        check("abort.pulse_count", pulse_cnt, exp_pulses);
        send(32'h81C3, 16);
        exp_pulses = exp_pulses + 1;
        check_regs("recover", 8'hF0, 8'hC3, 8'h01, 8'h55, 8'h3C);
        check("recover.pulse_count", pulse_cnt, exp_pulses);

        // Reset mid-frame after 10 bits of 0x80FF.
        ncs_low();
        shift_bits(32'h80FF >> 6, 10);
        rst_n = 1'b0;
        wait_clk(2);
        check_regs("midrst.in_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("midrst.pulse", {31'h0, cfg_wr_pulse}, 32'h0);
        rst_n = 1'b1;
        wait_clk(3);
        shift_bits(32'h80FF & 32'h3F, 6);
        ncs_high();
        check_regs("midrst.after", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("midrst.pulse_count", pulse_cnt, exp_pulses);
        send(32'h80FF, 16);
        exp_pulses = exp_pulses + 1;
        check_regs("midrst.next_frame", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        check("final.pulse_count", pulse_cnt, exp_pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
